// File: rtl/clkmeas_pkg.sv
// Shared widths, FSM encoding and default timeout for the clock period meter.
package clkmeas_pkg;

    localparam int unsigned CNT_W           = 32;
    localparam int unsigned TIMEOUT_DEFAULT = 32'd50000000;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

endpackage

// File: rtl/sync_edge.sv
// Synchronizes an asynchronous level into iclk and flags its rising/falling edges.
module sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic iclk,
    input  logic irst_n,
    input  logic iasync,
    output logic orise,
    output logic ofall,
    output logic olevel
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   sync_lvl;

    assign sync_lvl = sync_q[SYNC_STAGES-1];

    // Flags are registered so rise/fall/level stay aligned with each other.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            orise  <= 1'b0;
            ofall  <= 1'b0;
            olevel <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], iasync};
            prev_q <= sync_lvl;
            orise  <= sync_lvl & ~prev_q;
            ofall  <= ~sync_lvl & prev_q;
            olevel <= sync_lvl;
        end
    end

endmodule

// File: rtl/clock_period_meter.sv
// Measures period and high time of a slow asynchronous clock in iclk cycles,
// with a valid/ready result port, timeout and overrun pulses.
module clock_period_meter
    import clkmeas_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic             iclk,
    input  logic             irst_n,
    input  logic             isig,
    input  logic             iready,
    output logic             ovalid,
    output logic [CNT_W-1:0] operiod,
    output logic [CNT_W-1:0] ohigh,
    output logic             otimeout,
    output logic             ooverrun
);

    logic             rise, fall, level;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, high_q, cap_p_q, cap_h_q;
    logic             hi_done_q, load_q;
    logic             start_c, capture_c, timeout_c, count_c, at_limit_c;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_edge (
        .iclk   (iclk),
        .irst_n (irst_n),
        .iasync (isig),
        .orise  (rise),
        .ofall  (fall),
        .olevel (level)
    );

    assign at_limit_c = (cnt_q == CNT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // A rise always wins over the timeout threshold on the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (rise) state_d = MEASURE;
            MEASURE: if (!rise && at_limit_c) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        start_c   = 1'b0;
        capture_c = 1'b0;
        timeout_c = 1'b0;
        count_c   = 1'b0;
        case (state_q)
            IDLE: start_c = rise;
            MEASURE: begin
                if (rise) begin
                    capture_c = 1'b1;
                    start_c   = 1'b1;
                end else if (at_limit_c) begin
                    timeout_c = 1'b1;
                end else begin
                    count_c = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // High time counts only the high phase that opens the period.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            cnt_q     <= '0;
            high_q    <= '0;
            hi_done_q <= 1'b0;
        end else if (start_c) begin
            cnt_q     <= CNT_W'(1);
            high_q    <= CNT_W'(1);
            hi_done_q <= 1'b0;
        end else if (count_c) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (level && !hi_done_q) high_q <= high_q + CNT_W'(1);
            if (fall) hi_done_q <= 1'b1;
        end else if (timeout_c) begin
            cnt_q  <= '0;
            high_q <= '0;
        end
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            load_q  <= 1'b0;
            cap_p_q <= '0;
            cap_h_q <= '0;
        end else begin
            load_q <= capture_c;
            if (capture_c) begin
                cap_p_q <= cnt_q;
                cap_h_q <= high_q;
            end
        end
    end

    // Result register with valid/ready handshake and overwrite detection.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            ovalid   <= 1'b0;
            operiod  <= '0;
            ohigh    <= '0;
            otimeout <= 1'b0;
            ooverrun <= 1'b0;
        end else begin
            otimeout <= timeout_c;
            ooverrun <= 1'b0;
            if (load_q) begin
                operiod  <= cap_p_q;
                ohigh    <= cap_h_q;
                ovalid   <= 1'b1;
                ooverrun <= ovalid & ~iready;
            end else if (ovalid && iready) begin
                ovalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_clock_period_meter.sv
// Self-checking bench for clock_period_meter: directed scenarios plus random
// waveforms, compared cycle by cycle against a sample-history reference model.
module tb_clock_period_meter;

    localparam int unsigned TO = 1000;
    localparam int unsigned S  = 2;

    logic        iclk   = 1'b0;
    logic        irst_n = 1'b1;
    logic        isig   = 1'b0;
    logic        iready = 1'b1;
    logic        ovalid, otimeout, ooverrun;
    logic [31:0] operiod, ohigh;

    always #5 iclk = ~iclk;

    clock_period_meter #(.TIMEOUT_CYCLES(TO), .SYNC_STAGES(S)) dut (
        .iclk     (iclk),
        .irst_n   (irst_n),
        .isig     (isig),
        .iready   (iready),
        .ovalid   (ovalid),
        .operiod  (operiod),
        .ohigh    (ohigh),
        .otimeout (otimeout),
        .ooverrun (ooverrun)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned n_fail   = 0;

    // Reference model: isig samples since reset, measurement state, expected outputs.
    bit          samp[$];
    bit          m_meas, m_pend;
    int          m_last;
    int unsigned m_pend_p, m_pend_h;
    bit          e_valid, e_timeout, e_overrun;
    int unsigned e_period, e_high;

    // Per-segment observation counters.
    int unsigned n_to, n_ov, n_vc, to_cycle, first_cycle, first_p, first_h;
    bit          got_first;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic seg_clear();
        n_to = 0; n_ov = 0; n_vc = 0; to_cycle = 0;
        got_first = 1'b0; first_cycle = 0; first_p = 0; first_h = 0;
    endtask

    task automatic model_reset();
        samp.delete();
        m_meas = 1'b0; m_pend = 1'b0; m_last = 0;
        m_pend_p = 0; m_pend_h = 0;
        e_valid = 1'b0; e_timeout = 1'b0; e_overrun = 1'b0;
        e_period = 0; e_high = 0;
    endtask

    task automatic reset_dut();
        irst_n = 1'b0;
        isig   = 1'b0;
        #1;
        check("rst_ovalid", {31'd0, ovalid}, 32'd0);
        check("rst_operiod", operiod, 32'd0);
        check("rst_ohigh", ohigh, 32'd0);
        check("rst_otimeout", {31'd0, otimeout}, 32'd0);
        check("rst_ooverrun", {31'd0, ooverrun}, 32'd0);
        model_reset();
        repeat (2) @(posedge iclk);
        @(negedge iclk);
        irst_n = 1'b1;
    endtask

    // One iclk cycle: sample inputs at the edge, advance the model, compare outputs.
    task automatic step();
        int          m, k;
        bit          rise;
        int unsigned h;
        @(posedge iclk);
        samp.push_back(isig);
        m = samp.size() - 1;
        e_timeout = 1'b0;
        e_overrun = 1'b0;
        if (m_pend) begin
            e_overrun = e_valid && !iready;
            e_valid   = 1'b1;
            e_period  = m_pend_p;
            e_high    = m_pend_h;
        end else if (e_valid && iready) begin
            e_valid = 1'b0;
        end
        m_pend = 1'b0;
        k = m - int'(S) - 1;
        if (k >= 0) begin
            if (k == 0) rise = samp[0];
            else        rise = samp[k] && !samp[k-1];
            if (rise) begin
                if (m_meas) begin
                    h = 0;
                    for (int i = m_last; i < k; i++) h += 32'(samp[i]);
                    m_pend   = 1'b1;
                    m_pend_p = 32'(k - m_last);
                    m_pend_h = h;
                end
                m_meas = 1'b1;
                m_last = k;
            end else if (m_meas && (k - m_last) == int'(TO)) begin
                e_timeout = 1'b1;
                m_meas    = 1'b0;
            end
        end
        #1;
        check("ovalid", {31'd0, ovalid}, {31'd0, e_valid});
        check("operiod", operiod, e_period);
        check("ohigh", ohigh, e_high);
        check("otimeout", {31'd0, otimeout}, {31'd0, e_timeout});
        check("ooverrun", {31'd0, ooverrun}, {31'd0, e_overrun});
        if (otimeout) begin n_to++; to_cycle = 32'(m); end
        if (ooverrun) n_ov++;
        if (ovalid)   n_vc++;
        if (ovalid && !got_first) begin
            got_first   = 1'b1;
            first_cycle = 32'(m);
            first_p     = operiod;
            first_h     = ohigh;
        end
    endtask

    task automatic wave(input int unsigned hi, input int unsigned lo, input int unsigned periods);
        for (int p = 0; p < int'(periods); p++) begin
            isig = 1'b1;
            repeat (hi) step();
            isig = 1'b0;
            repeat (lo) step();
        end
    endtask

    initial begin
        int unsigned a, hi, lo;
        model_reset();
        seg_clear();
        #1;
        reset_dut();

        // 12/12 toggling with iready high: 9 results of 24/12, no overrun.
        iready = 1'b1;
        seg_clear();
        wave(12, 12, 10);
        check("tog_results", n_vc, 32'd9);
        check("tog_overrun", n_ov, 32'd0);
        check("tog_period", operiod, 32'd24);
        check("tog_high", ohigh, 32'd12);

        // Reset mid-period, then restart: first result on 2nd rise, latency S+2.
        isig = 1'b1;
        repeat (5) step();
        reset_dut();
        seg_clear();
        wave(12, 12, 4);
        check("rst_first_cycle", first_cycle, 32'd24 + S + 2);
        check("rst_first_period", first_p, 32'd24);
        check("rst_first_high", first_h, 32'd12);

        // 30/70 with iready low for three periods: two overwrites.
        seg_clear();
        iready = 1'b0;
        wave(30, 70, 3);
        check("ovr_count", n_ov, 32'd2);
        check("ovr_valid", {31'd0, ovalid}, 32'd1);
        check("ovr_period", operiod, 32'd100);
        check("ovr_high", ohigh, 32'd30);
        iready = 1'b1;
        repeat (3) step();

        // Single rise then held low: one timeout TO cycles after detection.
        reset_dut();
        seg_clear();
        isig = 1'b1;
        repeat (5) step();
        isig = 1'b0;
        repeat (1100) step();
        check("to_count", n_to, 32'd1);
        check("to_cycle", to_cycle, TO + S + 1);
        check("to_novalid", n_vc, 32'd0);

        // One-cycle pulses exactly TO apart: result, no timeout at the threshold.
        seg_clear();
        a = samp.size();
        isig = 1'b1;
        step();
        isig = 1'b0;
        repeat (TO - 1) step();
        isig = 1'b1;
        step();
        isig = 1'b0;
        repeat (10) step();
        check("coin_timeout", n_to, 32'd0);
        check("coin_cycle", first_cycle, a + TO + S + 2);
        check("coin_period", first_p, TO);
        check("coin_high", first_h, 32'd1);

        // Constant high: timeouts only.
        seg_clear();
        repeat (1000) step();
        isig = 1'b1;
        repeat (1200) step();
        check("const_hi_valid", n_vc, 32'd0);
        check("const_hi_timeouts", n_to, 32'd2);

        // Random waveforms and iready, periods occasionally near the threshold.
        isig = 1'b0;
        repeat (20) step();
        for (int p = 0; p < 30; p++) begin
            hi = $urandom_range(1, 40);
            if ($urandom_range(0, 5) == 0) lo = TO - hi - 1 + $urandom_range(0, 2);
            else                           lo = $urandom_range(1, 40);
            isig = 1'b1;
            repeat (hi) begin iready = 1'($urandom_range(0, 1)); step(); end
            isig = 1'b0;
            repeat (lo) begin iready = 1'($urandom_range(0, 1)); step(); end
        end
        iready = 1'b1;
        repeat (10) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/clock_period_meter.md
CLOCK_PERIOD_METER -- requirements
Module: clock_period_meter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 32'd50000000, meaning the iclk cycles without a rising edge on isig before timeout (1 s at 50 MHz).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning the synchronizer depth (legal values 2..3).
REQ-003 SHALL have port iclk, input, 1 bit: the 50 MHz master clock; the single clock of the block.
REQ-004 SHALL have port irst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port isig, input, 1 bit: the slow divided clock under measurement, asynchronous to iclk.
REQ-006 SHALL have port iready, input, 1 bit: the consumer accepts the result.
REQ-007 SHALL have port ovalid, output, 1 bit: operiod and ohigh hold a valid measurement.
REQ-008 SHALL have port operiod, output, 32 bits: iclk cycles between two successive rising edges of isig.
REQ-009 SHALL have port ohigh, output, 32 bits: iclk cycles isig was high within that period.
REQ-010 SHALL have port otimeout, output, 1 bit: one-cycle pulse on timeout.
REQ-011 SHALL have port ooverrun, output, 1 bit: one-cycle pulse when an unaccepted result is overwritten.

Function
REQ-012 SHALL pass isig through SYNC_STAGES flip-flops and then an edge register; the rise flag = synchronized high AND previous low, and the fall flag = synchronized low AND previous high.
REQ-013 SHALL implement FSM states IDLE (waiting for the first rise) and MEASURE (counting).
REQ-014 IDLE -> MEASURE on a rise flag; the period and high counters load 1.
REQ-015 In MEASURE, the period counter SHALL increment every cycle, and the high counter SHALL increment while the synchronized signal is high.
REQ-016 On a rise flag in MEASURE: operiod <= period count, ohigh <= high count, and ovalid <= 1 on the next cycle; the counters reload 1 and the FSM stays in MEASURE.
REQ-017 Result latency: ovalid asserts SYNC_STAGES+2 iclk edges after the first iclk edge that samples isig high.
REQ-018 Handshake: a result is transferred on a cycle with ovalid=1 and iready=1; ovalid then drops the next cycle unless a new result loads on the same cycle.
REQ-019 While ovalid=1, operiod and ohigh SHALL be held stable until transfer or overwrite.
REQ-020 Simultaneous new result and iready=1: the new result loads, ovalid stays 1, and ooverrun stays 0.
REQ-021 New result while ovalid=1 and iready=0: overwrite operiod and ohigh, keep ovalid=1, and pulse ooverrun for 1 cycle.
REQ-022 Timeout: in MEASURE, when the period count reaches TIMEOUT_CYCLES with no rise, SHALL pulse otimeout for 1 cycle and go to IDLE; a pending ovalid result is kept.
REQ-023 Counters SHALL never wrap; the timeout fires before the 32-bit limit.
REQ-024 A constant-high or constant-low isig SHALL produce timeouts only, never a valid result.
REQ-025 A rise on the same cycle as the timeout threshold SHALL count as a rise: a result is produced and there is no timeout.

Reset
REQ-026 irst_n low SHALL asynchronously force: FSM to IDLE, counters to 0, synchronizer and edge registers to 0, operiod/ohigh = 32'd0, and ovalid/otimeout/ooverrun = 0.
REQ-027 Reset asserted mid-measurement SHALL discard the partial count; after release, the first rise restarts from IDLE with no result.
REQ-028 Reset release SHALL be synchronized by the integrator; the block takes no action on the release edge beyond leaving reset.

Structure
REQ-029 SHALL place CNT_W = 32, the FSM state enum (IDLE, MEASURE) and the default TIMEOUT_CYCLES in package clkmeas_pkg.
REQ-030 SHALL place the synchronizer and edge detector in a sub-module sync_edge (ports: iclk, irst_n, iasync, orise, ofall, olevel), instantiated once.
REQ-031 The top module SHALL hold the FSM, counters, output registers and handshake.

Verification
REQ-032 isig toggles every 12 iclk, iready=1 -> from the 2nd rise on, operiod=24 and ohigh=12 on every result, and ooverrun stays 0.
REQ-033 isig with 30 cycles high and 70 cycles low, iready=0 for 3 periods -> ooverrun pulses twice, and the final ovalid shows operiod=100, ohigh=30.
REQ-034 TIMEOUT_CYCLES=1000, isig held low after one rise -> otimeout pulses once exactly 1000 cycles after that rise's detection, FSM goes to IDLE, no ovalid.
REQ-035 irst_n pulsed low mid-period during 24-cycle toggling -> all outputs are 0 immediately; the first result after release comes on the 2nd rise after release and equals 24/12.
REQ-036 One-cycle isig rise, SYNC_STAGES=2 -> ovalid asserts 4 iclk edges later; a rise coinciding with the timeout threshold yields a result, no otimeout.
